// File: rtl/round_robin_arbiter_pkg.sv
// rtl/round_robin_arbiter_pkg.sv - shared typedefs for the request arbitration pipeline
package round_robin_arbiter_pkg;

    // Arbiter control state: either no grant is outstanding or exactly one is held.
    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    // Per-stage pipeline control carried alongside selected data.
    typedef struct packed {
        logic valid;
        logic flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// rtl/rr_priority_encoder.sv - rotating first-set-bit search starting at a pointer
module rr_priority_encoder
    import round_robin_arbiter_pkg::*;
#(
    parameter int REQ_NUM     = 5,
    parameter int INDEX_WIDTH = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]     req,
    input  logic [INDEX_WIDTH-1:0] ptr,
    input  logic [REQ_NUM-1:0]     mask,
    output logic [REQ_NUM-1:0]     onehot,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   found
);

    logic [REQ_NUM-1:0]     eligible;
    int                     pos;
    logic [INDEX_WIDTH-1:0] pos_idx;

    assign eligible = req & ~mask;

    // Walk ptr, ptr+1, ... modulo REQ_NUM and keep the first eligible requester.
    always_comb begin
        onehot  = '0;
        index   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            pos = int'(ptr) + i;
            if (pos >= REQ_NUM) begin
                pos = pos - REQ_NUM;
            end
            pos_idx = INDEX_WIDTH'(pos);
            if (!found && eligible[pos_idx]) begin
                found           = 1'b1;
                onehot[pos_idx] = 1'b1;
                index           = pos_idx;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - registered one-hot round-robin arbiter with accept/flush
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int REQ_NUM     = 5,
    parameter int INDEX_WIDTH = $clog2(REQ_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQ_NUM-1:0]     req_in,
    input  logic                   flush_in,
    input  logic                   accept_in,
    output logic [REQ_NUM-1:0]     grant_out,
    output logic                   grant_valid_out,
    output logic [INDEX_WIDTH-1:0] grant_index_out,
    output logic [REQ_NUM-1:0]     ack_out
);

    arb_state_e             state_q, state_d;
    logic [REQ_NUM-1:0]     grant_q, grant_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic                   accept_hit;
    logic [INDEX_WIDTH-1:0] ptr_after_accept;
    logic [INDEX_WIDTH-1:0] enc_ptr;
    logic [REQ_NUM-1:0]     enc_mask;
    logic [REQ_NUM-1:0]     enc_onehot;
    logic [INDEX_WIDTH-1:0] enc_index;
    logic                   enc_found;

    // An accept only means something while a grant is actually held.
    assign accept_hit       = (state_q == GRANTED) && accept_in;
    assign ptr_after_accept = (index_q == INDEX_WIDTH'(REQ_NUM - 1)) ? '0
                                                                    : index_q + INDEX_WIDTH'(1);
    // On the accept edge search starts just past the winner and the winner is masked,
    // so the next grant is issued back-to-back without an idle cycle.
    assign enc_ptr          = accept_hit ? ptr_after_accept : ptr_q;
    assign enc_mask         = accept_hit ? grant_q : '0;

    rr_priority_encoder #(
        .REQ_NUM     (REQ_NUM),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_encoder (
        .req    (req_in),
        .ptr    (enc_ptr),
        .mask   (enc_mask),
        .onehot (enc_onehot),
        .index  (enc_index),
        .found  (enc_found)
    );

    // State register: grant, its index, and the priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: flush drops the grant outright but still lets an accept move ptr.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        if (accept_hit) begin
            ptr_d = ptr_after_accept;
        end
        if (flush_in) begin
            state_d = IDLE;
            grant_d = '0;
            index_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_found) begin
                        state_d = GRANTED;
                        grant_d = enc_onehot;
                        index_d = enc_index;
                    end
                end
                GRANTED: begin
                    if (accept_in) begin
                        if (enc_found) begin
                            grant_d = enc_onehot;
                            index_d = enc_index;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                            index_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    index_d = '0;
                end
            endcase
        end
    end

    // Outputs: everything but ack comes straight from registers; ack ignores flush.
    always_comb begin
        grant_out       = grant_q;
        grant_valid_out = |grant_q;
        grant_index_out = index_q;
        ack_out         = grant_q & {REQ_NUM{accept_in}};
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - scoreboard bench for round_robin_arbiter
module tb_round_robin_arbiter;

    localparam int N  = 5;
    localparam int IW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_in;
    logic          flush_in;
    logic          accept_in;
    logic [N-1:0]  grant_out;
    logic          grant_valid_out;
    logic [IW-1:0] grant_index_out;
    logic [N-1:0]  ack_out;

    typedef struct {
        logic [N-1:0] grant;
        int           index;
        logic         valid;
        logic [N-1:0] ack;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    bit   driving_done = 0;

    round_robin_arbiter #(
        .REQ_NUM     (N),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_in          (req_in),
        .flush_in        (flush_in),
        .accept_in       (accept_in),
        .grant_out       (grant_out),
        .grant_valid_out (grant_valid_out),
        .grant_index_out (grant_index_out),
        .ack_out         (ack_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act == expv) begin
            passed++;
        end else begin
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, expv);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected at mid-cycle.
    task automatic step(input logic r, input logic [N-1:0] req, input logic acc,
                        input logic fl, input logic [N-1:0] eg, input int ei,
                        input logic [N-1:0] ea, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        req_in    = req;
        accept_in = acc;
        flush_in  = fl;
        e.grant = eg;
        e.index = ei;
        e.valid = (eg != '0);
        e.ack   = ea;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs on the falling edge against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".grant"}, int'(grant_out), int'(e.grant));
                chk({e.name, ".index"}, int'(grant_index_out), e.index);
                chk({e.name, ".valid"}, int'(grant_valid_out), int'(e.valid));
                chk({e.name, ".ack"}, int'(ack_out), int'(e.ack));
                chk({e.name, ".onehot"}, int'($countones(grant_out) <= 1), 1);
            end
        end
    end

    initial begin
        rst = 1'b1; req_in = '0; accept_in = 1'b0; flush_in = 1'b0;
        //    rst  req       acc  fl   grant     idx ack
        step(1, 5'b00000, 0, 0, 5'b00000, 0, 5'b00000, "reset");
        step(0, 5'b00100, 0, 0, 5'b00000, 0, 5'b00000, "req2_lat");
        step(0, 5'b00100, 0, 0, 5'b00100, 2, 5'b00000, "req2_grant");
        step(0, 5'b00100, 1, 0, 5'b00100, 2, 5'b00100, "req2_accept");
        step(1, 5'b00000, 0, 0, 5'b00000, 0, 5'b00000, "reset2");
        step(0, 5'b11111, 1, 0, 5'b00000, 0, 5'b00000, "rot_idle");
        step(0, 5'b11111, 1, 0, 5'b00001, 0, 5'b00001, "rot0");
        step(0, 5'b11111, 1, 0, 5'b00010, 1, 5'b00010, "rot1");
        step(0, 5'b11111, 1, 0, 5'b00100, 2, 5'b00100, "rot2");
        step(0, 5'b11111, 1, 0, 5'b01000, 3, 5'b01000, "rot3");
        step(0, 5'b11111, 1, 0, 5'b10000, 4, 5'b10000, "rot4");
        step(0, 5'b00010, 1, 0, 5'b00001, 0, 5'b00001, "rot_wrap0");
        step(0, 5'b00000, 0, 0, 5'b00010, 1, 5'b00000, "hold1_a");
        step(0, 5'b00000, 0, 0, 5'b00010, 1, 5'b00000, "hold1_b");
        step(0, 5'b00000, 1, 0, 5'b00010, 1, 5'b00010, "hold1_acc");
        step(0, 5'b01000, 0, 0, 5'b00000, 0, 5'b00000, "to_idle");
        step(0, 5'b01001, 1, 0, 5'b01000, 3, 5'b01000, "g3_accept");
        step(0, 5'b10001, 0, 1, 5'b00001, 0, 5'b00000, "g0_flush");
        step(0, 5'b10001, 0, 0, 5'b00000, 0, 5'b00000, "flush_idle");
        step(0, 5'b00100, 1, 0, 5'b10000, 4, 5'b10000, "ptr4_grant");
        step(0, 5'b00100, 0, 1, 5'b00100, 2, 5'b00000, "g2_flush");
        step(0, 5'b00100, 0, 0, 5'b00000, 0, 5'b00000, "g2_flushed");
        step(0, 5'b00100, 1, 1, 5'b00100, 2, 5'b00100, "g2_again_flushacc");
        step(0, 5'b10001, 0, 0, 5'b00000, 0, 5'b00000, "flushacc_idle");
        step(0, 5'b10001, 0, 0, 5'b10000, 4, 5'b00000, "ptr3_grant4");
        step(1, 5'b10001, 1, 0, 5'b00000, 0, 5'b00000, "rst_mid_grant");
        step(0, 5'b10001, 0, 0, 5'b00000, 0, 5'b00000, "rst_release");
        step(0, 5'b00001, 1, 0, 5'b00001, 0, 5'b00001, "post_rst_g0");
        step(0, 5'b00001, 0, 0, 5'b00000, 0, 5'b00000, "mask_edge");
        step(0, 5'b00000, 0, 0, 5'b00001, 0, 5'b00000, "mask_released");
        driving_done = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 5, number of requesters (width of the one-hot grant fed to the downstream data selector).
REQ-002 SHALL have parameter INDEX_WIDTH, default $clog2(REQ_NUM), width of the binary grant index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_in  input  REQ_NUM  per-requester request level; held high until acknowledged.
REQ-006 flush_in  input  1  drops the current grant without acknowledging it.
REQ-007 accept_in  input  1  downstream consumed the granted requester's data this cycle.
REQ-008 grant_out  output  REQ_NUM  registered one-hot grant, drives the data selector's select input.
REQ-009 grant_valid_out  output  1  high iff grant_out is non-zero.
REQ-010 grant_index_out  output  INDEX_WIDTH  binary index of the set grant_out bit; 0 when no grant.
REQ-011 ack_out  output  REQ_NUM  combinational one-hot acknowledge, grant_out AND accept_in, not gated by flush_in.

Function
REQ-012 SHALL implement two states: IDLE (no grant held) and GRANTED (one grant held).
REQ-013 SHALL keep a priority pointer ptr (0..REQ_NUM-1); search order ptr, ptr+1, ..., wrapping modulo REQ_NUM.
REQ-014 IDLE: if any eligible req_in bit is set, SHALL register the first set bit in search order into grant_out and enter GRANTED next cycle (latency 1 cycle from request to grant).
REQ-015 IDLE with no eligible request: SHALL stay IDLE, grant_out = 0.
REQ-016 GRANTED: grant_out SHALL remain stable whatever req_in does until accept_in or flush_in is sampled high.
REQ-017 GRANTED with accept_in high: ptr SHALL become (granted index + 1) mod REQ_NUM; the same edge SHALL re-arbitrate among req_in with the just-accepted index masked, giving back-to-back grants with no idle cycle.
REQ-018 GRANTED with accept_in high and no other request: SHALL go IDLE, grant_out = 0.
REQ-019 flush_in high (any state): SHALL clear grant_out, enter IDLE, leave ptr unchanged; no re-arbitration that edge.
REQ-020 flush_in and accept_in both high: flush SHALL win for state; ack_out still asserts; ptr SHALL advance as for accept.
REQ-021 Masking of the accepted index SHALL apply only on the accept edge; from the next cycle it is eligible again.
REQ-022 With all REQ_NUM requesters permanently requesting and accept_in tied high, grants SHALL rotate 0,1,...,REQ_NUM-1,0 with one grant per cycle.
REQ-023 grant_out SHALL never have more than one bit set.
REQ-024 grant_index_out and grant_valid_out SHALL be derived from registered state only (no combinational path from inputs).

Reset
REQ-025 On rst high, asynchronously: grant_out = 0, grant_valid_out = 0, grant_index_out = 0, ptr = 0, state = IDLE.
REQ-026 Reset asserted mid-grant SHALL discard the grant with no ack; first grant after release follows REQ-014 with ptr = 0.
REQ-027 ack_out SHALL be 0 during reset because grant_out is 0.

Structure
REQ-028 State enum (IDLE, GRANTED) SHALL live in the shared package alongside existing pipeline typedefs.
REQ-029 Rotating first-set-bit search SHALL be a sub-module rr_priority_encoder (inputs request vector, pointer, mask; outputs one-hot and index), combinational.
REQ-030 grant_out SHALL connect directly to a data_selector sel_in without further gating.

Verification
REQ-031 Reset, then req_in=5'b00100 -> cycle+1 grant_out=5'b00100, grant_index_out=2, grant_valid_out=1.
REQ-032 req_in=5'b11111, accept_in=1 every cycle -> grant_index_out sequence 0,1,2,3,4,0.
REQ-033 Grant on index 1, req_in=5'b00010 dropped to 0 without accept -> grant_out stays 5'b00010 until accept_in.
REQ-034 Grant on index 3, req_in=5'b01001, accept_in=1 -> ack_out=5'b01000; next grant index 0, ptr=4.
REQ-035 Grant on index 2, flush_in=1 and accept_in=0 -> next cycle grant_out=0; with req_in=5'b00100, next grant is index 2 again.
REQ-036 rst pulsed while granting index 4 -> outputs 0 immediately; after release req_in=5'b10001 -> grant index 0.
